// File: rtl/cam_alloc_pkg.sv
// Shared status codes and FSM encoding for the CAM write-side allocator.
package cam_alloc_pkg;

    localparam logic [1:0] STATUS_OK        = 2'd0;
    localparam logic [1:0] STATUS_FULL      = 2'd1;
    localparam logic [1:0] STATUS_DUP       = 2'd2;
    localparam logic [1:0] STATUS_NOT_VALID = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_MATCH = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StCheck = ST_CHECK,
        StMatch = ST_MATCH,
        StIssue = ST_ISSUE,
        StWait  = ST_WAIT,
        StResp  = ST_RESP
    } state_e;

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder; LSB_PRIORITY "HIGH" picks the lowest set bit.
module priority_encoder #(
    parameter int    WIDTH        = 4,
    parameter string LSB_PRIORITY = "LOW"
) (
    input  logic [WIDTH-1:0]                          input_unencoded,
    output logic                                      output_valid,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] output_encoded,
    output logic [WIDTH-1:0]                          output_unencoded
);

    localparam int EncW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [EncW-1:0] enc;
    logic            hit;

    generate
        if (LSB_PRIORITY == "HIGH") begin : g_lsb
            always_comb begin
                hit = 1'b0;
                enc = '0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (input_unencoded[i]) begin
                        hit = 1'b1;
                        enc = i[EncW-1:0];
                    end
                end
            end
        end else begin : g_msb
            always_comb begin
                hit = 1'b0;
                enc = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (input_unencoded[i]) begin
                        hit = 1'b1;
                        enc = i[EncW-1:0];
                    end
                end
            end
        end
    endgenerate

    assign output_valid     = hit;
    assign output_encoded   = enc;
    assign output_unencoded = hit ? (WIDTH'(1) << enc) : '0;

endmodule

// File: rtl/cam_alloc.sv
// Write-side allocator for the SRL CAM: lowest-free slot insert, delete by address.
// Define CAM_ALLOC_DUP_CHECK_EN to reject duplicate keys through the CAM compare port.
module cam_alloc
    import cam_alloc_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      req_data,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic                       req_delete,
    input  logic                       req_valid,
    output logic                       req_ready,
    output logic [ADDR_WIDTH-1:0]      resp_addr,
    output logic [1:0]                 resp_status,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ADDR_WIDTH-1:0]      cam_write_addr,
    output logic [DATA_WIDTH-1:0]      cam_write_data,
    output logic                       cam_write_delete,
    output logic                       cam_write_enable,
    input  logic                       cam_write_busy,
    output logic [DATA_WIDTH-1:0]      cam_compare_data,
    input  logic                       cam_match,
    input  logic [ADDR_WIDTH-1:0]      cam_match_addr,
    output logic [(2**ADDR_WIDTH)-1:0] valid_map,
    output logic [ADDR_WIDTH:0]        count,
    output logic                       full,
    output logic                       empty
);

    localparam int                Slots     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CountOne  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] CountFull = (ADDR_WIDTH + 1)'(Slots);

    state_e                 state_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   delete_q;
    logic [Slots-1:0]       valid_map_q;
    logic [ADDR_WIDTH:0]    count_q;
    logic                   req_ready_q;
    logic                   resp_valid_q;
    logic [1:0]             resp_status_q;
    logic [ADDR_WIDTH-1:0]  resp_addr_q;

    logic                   free_valid;
    logic [ADDR_WIDTH-1:0]  free_addr;
    logic [Slots-1:0]       free_onehot;
    logic                   unused_enc;

    priority_encoder #(
        .WIDTH        (Slots),
        .LSB_PRIORITY ("HIGH")
    ) u_free_enc (
        .input_unencoded  (~valid_map_q),
        .output_valid     (free_valid),
        .output_encoded   (free_addr),
        .output_unencoded (free_onehot)
    );

    // Fullness comes from count, so the encoder's valid/one-hot outputs are not needed.
    assign unused_enc = free_valid ^ (^free_onehot);

`ifndef CAM_ALLOC_DUP_CHECK_EN
    logic unused_match;
    assign unused_match = cam_match ^ (^cam_match_addr);
`endif

    assign full  = (count_q == CountFull);
    assign empty = (count_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_status_q <= STATUS_OK;
            resp_addr_q   <= '0;
            valid_map_q   <= '0;
            count_q       <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        data_q      <= req_data;
                        addr_q      <= req_addr;
                        delete_q    <= req_delete;
                        if (!req_delete) begin
                            if (full) begin
                                resp_status_q <= STATUS_FULL;
                                resp_addr_q   <= '0;
                                resp_valid_q  <= 1'b1;
                                state_q       <= StResp;
                            end else begin
                                addr_q <= free_addr;
`ifdef CAM_ALLOC_DUP_CHECK_EN
                                state_q <= StCheck;
`else
                                state_q <= StIssue;
`endif
                            end
                        end else if (!valid_map_q[req_addr]) begin
                            resp_status_q <= STATUS_NOT_VALID;
                            resp_addr_q   <= req_addr;
                            resp_valid_q  <= 1'b1;
                            state_q       <= StResp;
                        end else begin
                            state_q <= StIssue;
                        end
                    end
                end
`ifdef CAM_ALLOC_DUP_CHECK_EN
                // CAM match is registered: give compare_data one cycle to settle.
                StCheck: state_q <= StMatch;
                StMatch: begin
                    if (cam_match) begin
                        resp_status_q <= STATUS_DUP;
                        resp_addr_q   <= cam_match_addr;
                        resp_valid_q  <= 1'b1;
                        state_q       <= StResp;
                    end else begin
                        state_q <= StIssue;
                    end
                end
`endif
                StIssue: begin
                    if (!cam_write_busy) begin
                        if (delete_q) begin
                            valid_map_q[addr_q] <= 1'b0;
                            count_q             <= count_q - CountOne;
                        end else begin
                            valid_map_q[addr_q] <= 1'b1;
                            count_q             <= count_q + CountOne;
                        end
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (!cam_write_busy) begin
                        resp_status_q <= STATUS_OK;
                        resp_addr_q   <= addr_q;
                        resp_valid_q  <= 1'b1;
                        state_q       <= StResp;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    // Enable is gated by live busy so it can never fire into a busy CAM.
    assign cam_write_enable = (state_q == StIssue) && !cam_write_busy;
    assign cam_write_addr   = addr_q;
    assign cam_write_data   = data_q;
    assign cam_write_delete = delete_q;
    assign cam_compare_data = data_q;

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_status = resp_status_q;
    assign resp_addr   = resp_addr_q;
    assign valid_map   = valid_map_q;
    assign count       = count_q;

endmodule

// File: doc/cam_alloc.md
Name: cam_alloc

Overview:
- Write-side initiator for the SRL-based CAM (cam_srl).
- Accepts insert-by-key and delete-by-address requests from a client.
- Allocates the lowest free CAM slot for each insert, drives the CAM write port honouring write_busy, and tracks a per-slot valid bitmap.
- Returns a status response per request; optionally rejects duplicate keys via the CAM compare port.

Parameters:
- DATA_WIDTH, 64, key width; must equal the CAM DATA_WIDTH.
- ADDR_WIDTH, 5, log2 of slot count; must equal the CAM ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_data  in  DATA_WIDTH  key to insert.
- req_addr  in  ADDR_WIDTH  slot to delete.
- req_delete  in  1  1 = delete, 0 = insert.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- resp_addr  out  ADDR_WIDTH  slot written or deleted.
- resp_status  out  2  0 OK, 1 FULL, 2 DUP, 3 NOT_VALID.
- resp_valid  out  1  response valid; held until resp_ready.
- resp_ready  in  1  response consumed.
- cam_write_addr  out  ADDR_WIDTH  to CAM write_addr.
- cam_write_data  out  DATA_WIDTH  to CAM write_data.
- cam_write_delete  out  1  to CAM write_delete.
- cam_write_enable  out  1  to CAM write_enable.
- cam_write_busy  in  1  from CAM write_busy.
- cam_compare_data  out  DATA_WIDTH  to CAM compare_data.
- cam_match  in  1  from CAM match.
- cam_match_addr  in  ADDR_WIDTH  from CAM match_addr.
- valid_map  out  2**ADDR_WIDTH  per-slot occupancy.
- count  out  ADDR_WIDTH+1  number of occupied slots.
- full  out  1  count == 2**ADDR_WIDTH.
- empty  out  1  count == 0.

Behaviour:
- Reset values:
  - state IDLE; req_ready 1; resp_valid 0; resp_status 0; resp_addr 0.
  - cam_write_enable 0; valid_map 0; count 0; empty 1; full 0.
  - Data registers are not reset.
- States: IDLE, CHECK, MATCH, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch data, addr and delete into registers.
  - Insert: if full, then status FULL, addr 0, go to RESP. Otherwise latch free_addr (lowest clear bit of valid_map) and go to CHECK (macro defined) or ISSUE.
  - Delete: if valid_map[req_addr]==0, then status NOT_VALID, addr req_addr, go to RESP. Otherwise go to ISSUE.
- req_ready=0 in every state except IDLE; one request is outstanding at a time.
- cam_compare_data continuously drives the latched data register.
- CHECK:
  - One-cycle wait; the CAM match output is registered, so match is valid one cycle after compare_data is stable.
  - Go to MATCH.
- MATCH:
  - If cam_match, then status DUP, resp_addr=cam_match_addr, go to RESP, no write.
  - Otherwise go to ISSUE.
- ISSUE:
  - Assert cam_write_enable for exactly one cycle, and only in a cycle where cam_write_busy==0; stay in ISSUE while busy.
  - cam_write_addr, cam_write_data and cam_write_delete are driven from the latched registers and are stable throughout ISSUE.
  - In the enable cycle, update valid_map and count: insert sets the bit and increments count; delete clears the bit and decrements count.
  - Go to WAIT.
- WAIT:
  - The CAM raises busy the cycle after enable.
  - When cam_write_busy==0, set status OK, resp_addr = latched slot, go to RESP.
  - CAM write takes 2**SLICE_WIDTH cycles, so WAIT lasts ≥ 16 cycles with SLICE_WIDTH=4.
- RESP:
  - resp_valid=1; outputs stable until resp_ready.
  - On resp_ready, go to IDLE.
  - Latency is 1 cycle minimum from accept to resp_valid for FULL/NOT_VALID.
- After reset the CAM holds busy during its init sweep. An insert accepted then waits in ISSUE, with no enable until busy drops.
- Reset mid-operation: return to IDLE immediately, clear valid_map and count, drop resp_valid and cam_write_enable. CAM shares rst, so occupancy stays consistent.
- count and full/empty are combinational from count and update in the same edge as valid_map.
- Deleting then re-inserting reuses the lowest free slot.
- No wrap-around: slot choice is purely lowest-free.

Optional Feature:
- CAM_ALLOC_DUP_CHECK_EN defined:
  - Inserts pass through CHECK and MATCH.
  - A key already present returns DUP with the matching slot.
  - Adds 2 cycles to insert latency.
- Undefined:
  - CHECK and MATCH are removed; insert goes directly IDLE→ISSUE.
  - DUP is never produced.
  - cam_compare_data is still driven; cam_match and cam_match_addr are ignored.

Decomposition:
- Package cam_alloc_pkg holds:
  - status codes STATUS_OK/FULL/DUP/NOT_VALID (2 bits);
  - state encoding localparams.
- Sub-module: the existing priority_encoder (LSB_PRIORITY "HIGH") on ~valid_map produces free_addr; no other sub-modules.

Test Plan:
- Reset, then insert 0x1234 while CAM is initialising: enable is withheld until busy=0; then OK with addr 0, count=1, valid_map=1, and the CAM matches 0x1234 at addr 0.
- Insert 32 distinct keys, then a 33rd: the first 32 return OK addr 0..31 in order and full=1; the 33rd returns FULL with no cam_write_enable pulse.
- Delete addr 5 (valid), then delete addr 5 again, then insert 0xAA: OK addr 5, then NOT_VALID addr 5, then OK addr 5; count ends at 32.
- With CAM_ALLOC_DUP_CHECK_EN, insert 0x55 twice: OK addr 0, then DUP addr 0, count stays 1. Without the macro, the second insert is OK addr 1.
- Hold resp_ready=0 for 10 cycles: resp_valid, resp_status and resp_addr stay stable and req_ready stays 0; one cycle after resp_ready=1, req_ready=1.
- Assert rst during WAIT: next cycle state IDLE, valid_map=0, count=0, resp_valid=0; the next insert gets addr 0 after the CAM init completes.
